// File: rtl/rr_encoder_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// Handshake: a requester raises req[i] and holds it until its grant
// ends. gnt/gnt_idx/gnt_valid are registered and change only on clock edges.
// done is meaningful only while gnt_valid=1 and ends the current grant at
// the next edge. A held grant is never preempted.
interface rr_encoder_arbiter_if;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    // Requester side: drives requests/completion, observes grants.
    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    // Arbiter side: observes requests/completion, drives grants.
    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_encoder_arbiter.sv
// 16-way round-robin arbiter with a registered one-hot grant, its 4-bit
// encoded index, and a hold limit that forces release after MAX_HOLD cycles.
// Every grant is followed by at least one idle cycle.
module rr_encoder_arbiter #(
    parameter int unsigned MAX_HOLD = 8,   // 1..255
    parameter int unsigned CNT_W    = 8    // 2**CNT_W > MAX_HOLD
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    rr_encoder_arbiter_if.slave  bus,
    output logic                 state_o,  // 0 = IDLE, 1 = BUSY
    output logic [3:0]           ptr_o     // current search start
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        gnt_q, gnt_d;
    logic [3:0]         idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;

    logic               win_found;
    logic [3:0]         win_idx;
    logic [3:0]         cand;
    logic               owner_req;
    logic               hold_hit;

    // Circular priority search starting at ptr_q; walking the offsets from
    // high to low lets the smallest offset with a set bit overwrite the rest.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 4'd0;
        cand      = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            cand = ptr_q + 4'(i);
            if (bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/BUSY controller.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        owner_req = bus.req[idx_q];
        hold_hit  = (cnt_q == HOLD_LAST);

        case (state_q)
            ST_IDLE: begin
                gnt_d   = 16'h0000;
                idx_d   = 4'd0;
                valid_d = 1'b0;
                if (win_found) begin
                    gnt_d   = 16'h0001 << win_idx;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.done || !owner_req || hold_hit) begin
                    // Timeout flags only a release caused purely by the limit.
                    timeout_d = hold_hit && !bus.done && owner_req;
                    gnt_d     = 16'h0000;
                    idx_d     = 4'd0;
                    valid_d   = 1'b0;
                    ptr_d     = idx_q + 4'd1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 16'h0000;
                idx_d   = 4'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 4'd0;
            cnt_q     <= '0;
            gnt_q     <= 16'h0000;
            idx_q     <= 4'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = timeout_q;
    assign state_o       = state_q;
    assign ptr_o         = ptr_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed bench for rr_encoder_arbiter (MAX_HOLD=8): reset, single grant,
// round-robin order, hold-limit timeout, request drop and async reset.
module tb_rr_encoder_arbiter;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic       state_dbg;
    logic [3:0] ptr_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_encoder_arbiter_if bus ();

    rr_encoder_arbiter #(
        .MAX_HOLD (8),
        .CNT_W    (8)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus),
        .state_o (state_dbg),
        .ptr_o   (ptr_dbg)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},   32'(bus.gnt),       32'h0);
        check({tag, "_idx"},   32'(bus.gnt_idx),   32'h0);
        check({tag, "_valid"}, 32'(bus.gnt_valid), 32'h0);
    endtask

    // Grant invariants, checked mid-cycle whenever reset is released.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("inv_onehot", 32'($onehot0(bus.gnt)), 32'h1);
            check("inv_valid",  32'(bus.gnt_valid),     32'(|bus.gnt));
            if (bus.gnt_valid === 1'b1)
                check("inv_enc", 32'(bus.gnt), 32'h1 << bus.gnt_idx);
        end
    end

    // Run bound in case the DUT stalls the sequence.
    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n    = 1'b0;
        bus.req  = 16'hFFFF;
        bus.done = 1'b0;

        // Reset held with all requests active.
        for (int c = 0; c < 3; c++) begin
            tick();
            check_idle("rst");
            check("rst_timeout", 32'(bus.timeout), 32'h0);
        end
        rst_n = 1'b1;
        tick();
        check("first_gnt", 32'(bus.gnt),     32'h0001);
        check("first_idx", 32'(bus.gnt_idx), 32'h0);
        bus.req = 16'h0000;
        tick();
        check_idle("first_rel");
        check("first_ptr", 32'(ptr_dbg), 32'h1);

        // Single request released by done.
        bus.req = 16'h0400;
        tick();
        check("single_gnt", 32'(bus.gnt),     32'h0400);
        check("single_idx", 32'(bus.gnt_idx), 32'd10);
        tick();
        tick();
        check("single_hold", 32'(bus.gnt_valid), 32'h1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 16'h0000;
        check_idle("single_rel");
        check("single_ptr",     32'(ptr_dbg),     32'd11);
        check("single_timeout", 32'(bus.timeout), 32'h0);

        // done while idle is ignored.
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check_idle("idle_done");
        check("idle_done_state", 32'(state_dbg), 32'h0);

        // Round-robin order 0, 2, 15, 0 from Ptr=0.
        reset_pulse();
        check("rr_ptr0", 32'(ptr_dbg), 32'h0);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd0);
        bus.req = 16'h8005;
        for (int g = 0; g < 4; g++) begin
            exp_idx = exp_q.pop_front();
            tick();
            check("rr_valid", 32'(bus.gnt_valid), 32'h1);
            check("rr_idx",   32'(bus.gnt_idx),   32'(exp_idx));
            tick();
            check("rr_idx2",  32'(bus.gnt_idx),   32'(exp_idx));
            bus.done = 1'b1;
            if (g == 3) bus.req = 16'h0000;
            tick();
            bus.done = 1'b0;
            check_idle("rr_gap");
            check("rr_timeout", 32'(bus.timeout), 32'h0);
        end
        check("rr_ptr_end", 32'(ptr_dbg), 32'h1);

        // Hold limit: 8 grant cycles, then a timeout pulse, then regrant.
        bus.req = 16'h0020;
        tick();
        for (int k = 1; k <= 8; k++) begin
            check("to_valid",   32'(bus.gnt_valid), 32'h1);
            check("to_idx",     32'(bus.gnt_idx),   32'd5);
            check("to_pulse_lo", 32'(bus.timeout),  32'h0);
            tick();
        end
        check_idle("to_rel");
        check("to_pulse", 32'(bus.timeout), 32'h1);
        check("to_ptr",   32'(ptr_dbg),     32'd6);
        tick();
        check("to_regrant", 32'(bus.gnt),     32'h0020);
        check("to_pulse_1", 32'(bus.timeout), 32'h0);
        bus.req = 16'h0000;
        tick();
        check_idle("to_drop");
        check("to_drop_timeout", 32'(bus.timeout), 32'h0);

        // Request drop by owner 3; other requests wait and search from 4.
        reset_pulse();
        bus.req = 16'h0008;
        tick();
        check("drop_idx", 32'(bus.gnt_idx), 32'd3);
        bus.req = 16'h010A;
        tick();
        check("drop_nopreempt", 32'(bus.gnt), 32'h0008);
        bus.req = 16'h0102;
        tick();
        check_idle("drop_rel");
        check("drop_timeout", 32'(bus.timeout), 32'h0);
        check("drop_ptr",     32'(ptr_dbg),     32'd4);
        tick();
        check("drop_next", 32'(bus.gnt_idx), 32'd8);
        bus.done = 1'b1;
        bus.req  = 16'h0000;
        tick();
        bus.done = 1'b0;
        check_idle("drop_end");

        // Asynchronous reset in the middle of a grant.
        bus.req = 16'h0200;
        tick();
        check("ar_idx", 32'(bus.gnt_idx), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("ar_clear");
        check("ar_ptr",   32'(ptr_dbg),   32'h0);
        check("ar_state", 32'(state_dbg), 32'h0);
        bus.req = 16'h0201;
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_regrant_idx", 32'(bus.gnt_idx), 32'd0);
        check("ar_regrant_gnt", 32'(bus.gnt),     32'h0001);
        bus.req = 16'h0000;
        tick();

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
